// File: rtl/lvds_rx_frame_pkg.sv
// Shared constants, state encoding and word decode helpers for the LVDS RX frame parser.
package lvds_rx_frame_pkg;
   localparam logic [9:0] COMMA1  = 10'b01_0111_1100;
   localparam logic [9:0] COMMA2  = 10'b10_1000_0011;
   localparam logic [9:0] SOF_DEF = 10'h0F5;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_CHK   = 2'b01;
   localparam logic [1:0] ERR_LEN   = 2'b10;
   localparam logic [1:0] ERR_ABORT = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_PAY, ST_CHK} state_t;

   function automatic logic is_comma(input logic [9:0] w);
      return (w == COMMA1) || (w == COMMA2);
   endfunction
endpackage

// File: rtl/lvds_rx_frame_sat_cnt.sv
// Saturating up-counter used for the frame statistics; sticks at all-ones.
module lvds_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             rx_clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);
   always_ff @(posedge rx_clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (inc && (q != {CNT_W{1'b1}}))
         q <= q + 1'b1;
   end
endmodule

// File: rtl/lvds_rx_frame.sv
// Frame parser behind the LVDS word aligner: strips commas, checks SOF/LEN/payload/CHK
// frames, streams payload out and keeps saturating good/bad frame counts.
module lvds_rx_frame
   import lvds_rx_frame_pkg::*;
#(
   parameter logic [9:0] SOF_WORD  = SOF_DEF,
   parameter int         BAD_LIMIT = 8,
   parameter int         CNT_W     = 16
) (
   input  logic             rx_clk,
   input  logic             rst_n,
   input  logic [9:0]       rx_data,
   input  logic             clk_align_done,
   output logic [9:0]       out_data,
   output logic             out_valid,
   output logic             out_last,
   output logic             frame_ok,
   output logic             frame_err,
   output logic [1:0]       err_code,
   output logic             realign_req,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);
   localparam int BW = $clog2(BAD_LIMIT + 1);

   state_t         state, state_nx;
   logic [9:0]     d_q, chk, chk_nx;
   logic [7:0]     rem, rem_nx;
   logic [BW-1:0]  bad_cnt, bad_nx;
   logic [9:0]     data_nx;
   logic           valid_nx, last_nx, ok_nx, err_nx, realign_nx;
   logic [1:0]     code_nx;

   always_ff @(posedge rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q         <= '0;
         state       <= ST_IDLE;
         chk         <= '0;
         rem         <= '0;
         bad_cnt     <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         frame_ok    <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= ERR_NONE;
         realign_req <= 1'b0;
      end else begin
         d_q         <= rx_data;
         state       <= state_nx;
         chk         <= chk_nx;
         rem         <= rem_nx;
         bad_cnt     <= bad_nx;
         out_data    <= data_nx;
         out_valid   <= valid_nx;
         out_last    <= last_nx;
         frame_ok    <= ok_nx;
         frame_err   <= err_nx;
         err_code    <= code_nx;
         realign_req <= realign_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      chk_nx     = chk;
      rem_nx     = rem;
      bad_nx     = bad_cnt;
      data_nx    = '0;
      valid_nx   = 1'b0;
      last_nx    = 1'b0;
      ok_nx      = 1'b0;
      err_nx     = 1'b0;
      code_nx    = ERR_NONE;
      realign_nx = 1'b0;
      // Losing lock overrides everything: abort any open frame and park in IDLE.
      if (!clk_align_done) begin
         state_nx = ST_IDLE;
         bad_nx   = '0;
         if (state != ST_IDLE) begin
            err_nx  = 1'b1;
            code_nx = ERR_ABORT;
         end
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (d_q == SOF_WORD) begin
                  state_nx = ST_LEN;
                  bad_nx   = '0;
               end else if (is_comma(d_q)) begin
                  bad_nx = '0;
               end else if (bad_cnt == BW'(BAD_LIMIT - 1)) begin
                  realign_nx = 1'b1;
                  bad_nx     = '0;
               end else begin
                  bad_nx = bad_cnt + 1'b1;
               end
            end
            ST_LEN: begin
               chk_nx = '0;
               rem_nx = d_q[7:0];
               if (d_q[7:0] == 8'd0) begin
                  err_nx   = 1'b1;
                  code_nx  = ERR_LEN;
                  state_nx = ST_IDLE;
               end else begin
                  state_nx = ST_PAY;
               end
            end
            ST_PAY: begin
               data_nx  = d_q;
               valid_nx = 1'b1;
               chk_nx   = chk ^ d_q;
               rem_nx   = rem - 8'd1;
               if (rem == 8'd1) begin
                  last_nx  = 1'b1;
                  state_nx = ST_CHK;
               end
            end
            ST_CHK: begin
               if (d_q == chk) begin
                  ok_nx = 1'b1;
               end else begin
                  err_nx  = 1'b1;
                  code_nx = ERR_CHK;
               end
               state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   lvds_sat_cnt #(.CNT_W(CNT_W)) u_frame_cnt (
      .rx_clk (rx_clk),
      .rst_n  (rst_n),
      .inc    (ok_nx),
      .q      (frame_cnt)
   );

   lvds_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
      .rx_clk (rx_clk),
      .rst_n  (rst_n),
      .inc    (err_nx),
      .q      (err_cnt)
   );
endmodule

// File: tb/tb_lvds_rx_frame.sv
// Directed bench for lvds_rx_frame; a second 2-bit-counter instance exercises saturation.
module tb_lvds_rx_frame;
   localparam logic [9:0] CM  = 10'h17C;
   localparam logic [9:0] SOF = 10'h0F5;

   logic        rx_clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rx_data;
   logic        clk_align_done;

   logic [9:0]  out_data, out_data_s;
   logic        out_valid, out_last, frame_ok, frame_err, realign_req;
   logic        out_valid_s, out_last_s, frame_ok_s, frame_err_s, realign_req_s;
   logic [1:0]  err_code, err_code_s;
   logic [15:0] frame_cnt, err_cnt;
   logic [1:0]  frame_cnt_s, err_cnt_s;

   int n_vec = 0, n_miss = 0;
   int m_valid = 0, m_sum = 0, m_last = 0, m_ok = 0, m_err = 0, m_realign = 0;
   logic [1:0] m_code = 2'b00;
   int s_valid, s_sum, s_last, s_ok, s_err, s_realign;

   always #5 rx_clk = ~rx_clk;

   lvds_rx_frame dut (
      .rx_clk(rx_clk), .rst_n(rst_n), .rx_data(rx_data), .clk_align_done(clk_align_done),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
      .realign_req(realign_req), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   lvds_rx_frame #(.CNT_W(2)) dut_s (
      .rx_clk(rx_clk), .rst_n(rst_n), .rx_data(rx_data), .clk_align_done(clk_align_done),
      .out_data(out_data_s), .out_valid(out_valid_s), .out_last(out_last_s),
      .frame_ok(frame_ok_s), .frame_err(frame_err_s), .err_code(err_code_s),
      .realign_req(realign_req_s), .frame_cnt(frame_cnt_s), .err_cnt(err_cnt_s)
   );

   always @(negedge rx_clk) begin
      if (out_valid) begin m_valid++; m_sum += int'(out_data); end
      if (out_last) m_last++;
      if (frame_ok) m_ok++;
      if (frame_err) begin m_err++; m_code = err_code; end
      if (realign_req) m_realign++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input logic [9:0] w);
      rx_data = w;
      @(negedge rx_clk);
      #1;
   endtask

   task automatic snap();
      s_valid = m_valid; s_sum = m_sum; s_last = m_last;
      s_ok = m_ok; s_err = m_err; s_realign = m_realign;
   endtask

   initial begin
      rst_n = 1'b0;
      clk_align_done = 1'b0;
      rx_data = CM;
      repeat (3) @(negedge rx_clk);
      #1;
      check("rst_outs", {21'd0, out_data, out_valid, out_last, frame_ok, frame_err,
                         err_code, realign_req}, 32'd0);
      check("rst_cnts", {frame_cnt, err_cnt}, 32'd0);
      rst_n = 1'b1;
      clk_align_done = 1'b1;

      // 1: good frame with cycle-exact checks
      step(CM); step(CM);
      step(SOF); step(10'd3);
      check("t1_sof_novalid", {31'd0, out_valid}, 32'd0);
      step(10'h001); step(10'h002);
      check("t1_w0", {20'd0, out_valid, out_last, out_data}, {20'd0, 2'b10, 10'h001});
      step(10'h004);
      check("t1_w1", {20'd0, out_valid, out_last, out_data}, {20'd0, 2'b10, 10'h002});
      step(10'h007);
      check("t1_w2_last", {20'd0, out_valid, out_last, out_data}, {20'd0, 2'b11, 10'h004});
      step(CM);
      check("t1_ok", {30'd0, frame_ok, frame_err}, 32'b10);
      check("t1_fcnt", frame_cnt, 32'd1);
      step(CM);
      check("t1_ok_pulse", {31'd0, frame_ok}, 32'd0);

      // 2: checksum error
      snap();
      step(SOF); step(10'd3); step(10'h001); step(10'h002); step(10'h004); step(10'h006);
      step(CM); step(CM);
      check("t2_nvalid", m_valid - s_valid, 32'd3);
      check("t2_sum", m_sum - s_sum, 32'd7);
      check("t2_nlast", m_last - s_last, 32'd1);
      check("t2_err", {m_ok - s_ok, m_err - s_err}, {32'd0, 32'd1} >> 0);
      check("t2_code", m_code, 32'b01);
      check("t2_cnts", {frame_cnt, err_cnt}, {16'd1, 16'd1});

      // 3: zero length (upper LEN bits ignored), then a 1-word frame with LEN upper bits set
      snap();
      step(SOF); step(10'h300); step(CM); step(CM);
      check("t3_err", m_err - s_err, 32'd1);
      check("t3_code", m_code, 32'b10);
      check("t3_novalid", m_valid - s_valid, 32'd0);
      check("t3_errcnt", err_cnt, 32'd2);
      snap();
      step(SOF); step(10'h301); step(10'h3FF); step(10'h3FF); step(CM); step(CM);
      check("t3b_ok", {m_ok - s_ok, m_valid - s_valid, m_last - s_last}, {32'd1, 32'd1, 32'd1});
      check("t3b_fcnt", frame_cnt, 32'd2);

      // 4: abort after two payload words; align-low idle noise must not realign
      snap();
      step(SOF); step(10'd5); step(10'h010); step(10'h020); step(10'h030);
      clk_align_done = 1'b0;
      step(10'h155);
      check("t4_abort_pulse", {29'd0, out_valid, frame_err, err_code},
            {29'd0, 1'b0, 1'b1, 2'b11});
      repeat (10) step(10'h155);
      check("t4_nvalid", m_valid - s_valid, 32'd2);
      check("t4_nolast", m_last - s_last, 32'd0);
      check("t4_err", {m_err - s_err, m_realign - s_realign}, {32'd1, 32'd0});
      check("t4_cnts", {frame_cnt, err_cnt}, {16'd2, 16'd3});
      clk_align_done = 1'b1;
      snap();
      step(CM); step(CM);
      // comma and SOF values inside payload are plain data
      step(SOF); step(10'd2); step(CM); step(SOF); step(10'h189); step(CM); step(CM);
      check("t4b_ok", {m_ok - s_ok, m_err - s_err, m_valid - s_valid}, {32'd1, 32'd0, 32'd2});
      check("t4b_sum", m_sum - s_sum, 32'h17C + 32'h0F5);
      check("t4b_fcnt", frame_cnt, 32'd3);

      // 5: realign after exactly BAD_LIMIT bad idle words; a comma breaks the run
      snap();
      repeat (7) step(10'h155);
      step(CM);
      check("t5_seven_no_req", m_realign - s_realign, 32'd0);
      repeat (8) step(10'h155);
      step(CM); step(CM);
      check("t5_one_req", m_realign - s_realign, 32'd1);
      snap();
      repeat (6) step(10'h155);
      step(CM);
      step(10'h155);
      step(CM); step(CM);
      check("t5_comma_breaks", m_realign - s_realign, 32'd0);

      // 6: back-to-back frames with no idle, then saturation on the 2-bit instance
      snap();
      step(SOF); step(10'd1); step(10'h005); step(10'h005);
      step(SOF); step(10'd1); step(10'h00A); step(10'h00A);
      step(CM); step(CM);
      check("t6_b2b_ok", {m_ok - s_ok, m_err - s_err}, {32'd2, 32'd0});
      check("t6_cnts", {frame_cnt, err_cnt}, {16'd5, 16'd3});
      check("t6_sat", {frame_cnt_s, err_cnt_s}, {2'd3, 2'd3});

      // reset mid-frame
      step(SOF); step(10'd3); step(10'h011); step(10'h022);
      check("t6_midframe_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_outs", {21'd0, out_data, out_valid, out_last, frame_ok, frame_err,
                            err_code, realign_req}, 32'd0);
      check("t6_rst_cnts", {frame_cnt, err_cnt, frame_cnt_s, err_cnt_s}, 32'd0);
      step(10'h033); step(CM);
      rst_n = 1'b1;
      step(CM); step(CM);
      step(SOF); step(10'd1); step(10'h0AA); step(10'h0AA); step(CM); step(CM);
      check("t6_after_rst", {frame_cnt, err_cnt}, {16'd1, 16'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
